// File: rtl/rem_sign_check.sv
// rem_sign_check
//   Sequential back-multiply remainder checker for the divider datapath.
//   Given a dividend n, a divisor d and a quotient estimate q that carries
//   ULP guard bits, it forms r = (n << FRAC) - Qh*d, where Qh is q with its
//   low ULP-1 bits cleared and the first guard bit q[ULP-1] kept. It then
//   reports the sign of r. The product is built one Qh bit per cycle with
//   shift-add, starting at the MSB.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high
//   start            request; only sampled while idle
//   n, d, q          dividend, divisor, quotient estimate (WIDTH bits each)
//   busy             high while the multiply or compare is in progress
//   valid            one-cycle pulse; flags and q_out are valid
//   q_out            q as captured at start, unmodified
//   rem_is_positive  r > 0
//   rem_is_negative  r < 0
//   rem_is_zero      r == 0
module rem_sign_check #(
    parameter int WIDTH = 28,
    parameter int ULP   = 4,
    parameter int FRAC  = WIDTH - 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] q_out,
    output logic             rem_is_positive,
    output logic             rem_is_negative,
    output logic             rem_is_zero
);

    // Qh bits WIDTH-1 down to ULP-1
    localparam int ITER = WIDTH - ULP + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, CMP} state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] n_r, d_r, q_cap, q_sh;
    logic [PW-1:0]    acc, acc_step;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [PW:0]      a_ext, r;

    assign last = (cnt == CW'(ITER - 1));

    // q_sh holds the captured quotient, shifted left once per MUL cycle, so
    // its MSB is always the Qh bit for the current iteration.
    assign acc_step = (acc << 1) + (q_sh[WIDTH-1] ? {{WIDTH{1'b0}}, d_r} : {PW{1'b0}});

    // One extra bit above the 2*WIDTH product keeps the difference exact.
    // Its top bit is the sign of r.
    assign a_ext = {{(PW + 1 - WIDTH){1'b0}}, n_r} << FRAC;
    assign r     = a_ext - {1'b0, acc};

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = MUL;
            MUL: begin
                busy = 1'b1;
                if (last) state_nxt = CMP;
            end
            CMP: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            valid           <= 1'b0;
            q_out           <= '0;
            rem_is_positive <= 1'b0;
            rem_is_negative <= 1'b0;
            rem_is_zero     <= 1'b0;
            n_r             <= '0;
            d_r             <= '0;
            q_cap           <= '0;
            q_sh            <= '0;
            acc             <= '0;
            cnt             <= '0;
        end else begin
            state <= state_nxt;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_r   <= n;
                        d_r   <= d;
                        q_cap <= q;
                        q_sh  <= q;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    q_sh <= q_sh << 1;
                    cnt  <= cnt + CW'(1);
                    // The last step drops the cleared low quotient bits.
                    // It re-weights the partial product to full Qh*D scale.
                    acc  <= last ? (acc_step << (ULP - 1)) : acc_step;
                end
                CMP: begin
                    rem_is_negative <= r[PW];
                    rem_is_zero     <= (r == '0);
                    rem_is_positive <= !r[PW] && (r != '0);
                    q_out           <= q_cap;
                    valid           <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
